// File: rtl/rename_map_pkg.sv
// Shared definitions for the rename stage.
//   - Geometry of the dispatch group, physical and architectural register files.
//   - phys_reg_t / log_reg_t register-number types, free_cnt_t for the freelist count.
//   - rename_out_t: one renamed slot as it is handed to dispatch/ROB.
//   - popcount2: number of set bits in a 2-bit slot mask.
package rename_map_pkg;

  localparam int DISPATCH_WIDTH       = 2;
  localparam int PHYS_REGS            = 64;
  localparam int PHYS_REGS_ADDR_WIDTH = $clog2(PHYS_REGS);
  localparam int LOG_REGS             = 32;
  localparam int LOG_REGS_ADDR_WIDTH  = $clog2(LOG_REGS);
  // Free count must be able to represent PHYS_REGS itself.
  localparam int FREE_CNT_WIDTH       = PHYS_REGS_ADDR_WIDTH + 1;
  // Two sources per slot, two slots.
  localparam int RAT_READ_PORTS       = 4;

  typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_reg_t;
  typedef logic [LOG_REGS_ADDR_WIDTH-1:0]  log_reg_t;
  typedef logic [FREE_CNT_WIDTH-1:0]       free_cnt_t;

  typedef struct packed {
    logic      inst_valid;
    phys_reg_t rd_phys;
    phys_reg_t old_rd_phys;
    phys_reg_t rs1_phys;
    phys_reg_t rs2_phys;
  } rename_out_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/rename_map_if.sv
// Bundle of every non-clock signal of the rename stage.
//   decode side : in_valid/in_ready handshake, per-slot inst_valid, rd_wen, rd, rs1, rs2
//   freelist    : fl_pop_en (out), fl_pop_reg, fl_num_free (in)
//   control     : flush
//   dispatch    : out_valid/out_ready handshake, renamed per-slot fields
//   retire      : commit_en, commit_rd, commit_phys
// Modport slave is the rename block's view, master is the surrounding pipeline's view.
interface rename_map_if;
  import rename_map_pkg::*;

  logic                                in_valid;
  logic                                in_ready;
  logic      [DISPATCH_WIDTH-1:0]      in_inst_valid;
  logic      [DISPATCH_WIDTH-1:0]      in_rd_wen;
  log_reg_t  [DISPATCH_WIDTH-1:0]      in_rd;
  log_reg_t  [DISPATCH_WIDTH-1:0]      in_rs1;
  log_reg_t  [DISPATCH_WIDTH-1:0]      in_rs2;

  logic      [DISPATCH_WIDTH-1:0]      fl_pop_en;
  phys_reg_t [DISPATCH_WIDTH-1:0]      fl_pop_reg;
  free_cnt_t                           fl_num_free;

  logic                                flush;

  logic                                out_valid;
  logic                                out_ready;
  logic      [DISPATCH_WIDTH-1:0]      out_inst_valid;
  phys_reg_t [DISPATCH_WIDTH-1:0]      out_rd_phys;
  phys_reg_t [DISPATCH_WIDTH-1:0]      out_old_rd_phys;
  phys_reg_t [DISPATCH_WIDTH-1:0]      out_rs1_phys;
  phys_reg_t [DISPATCH_WIDTH-1:0]      out_rs2_phys;

  logic      [DISPATCH_WIDTH-1:0]      commit_en;
  log_reg_t  [DISPATCH_WIDTH-1:0]      commit_rd;
  phys_reg_t [DISPATCH_WIDTH-1:0]      commit_phys;

  modport slave (
    input  in_valid, in_inst_valid, in_rd_wen, in_rd, in_rs1, in_rs2,
    output in_ready,
    output fl_pop_en,
    input  fl_pop_reg, fl_num_free,
    input  flush,
    output out_valid, out_inst_valid, out_rd_phys, out_old_rd_phys, out_rs1_phys, out_rs2_phys,
    input  out_ready,
    input  commit_en, commit_rd, commit_phys
  );

  modport master (
    output in_valid, in_inst_valid, in_rd_wen, in_rd, in_rs1, in_rs2,
    input  in_ready,
    input  fl_pop_en,
    output fl_pop_reg, fl_num_free,
    output flush,
    input  out_valid, out_inst_valid, out_rd_phys, out_old_rd_phys, out_rs1_phys, out_rs2_phys,
    output out_ready,
    output commit_en, commit_rd, commit_phys
  );

endinterface

// File: rtl/rename_map_rat_table.sv
// rat_table: LOG_REGS-entry map from architectural to physical register.
//   clk, rst        : clock, synchronous active-high reset (all entries -> p0)
//   rd_addr_i/rd_data_o : 4 combinational read ports, x0 always reads p0
//   wr_en_i/wr_addr_i/wr_data_i : 2 write ports, port 1 wins on equal address,
//                     writes to x0 are dropped
//   restore_i/restore_data_i : bulk load of the whole table, overrides writes
//   table_q_o       : current contents
//   table_d_o       : contents after this cycle's writes/restore (for bypassing)
module rat_table
  import rename_map_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  log_reg_t  [RAT_READ_PORTS-1:0]    rd_addr_i,
  output phys_reg_t [RAT_READ_PORTS-1:0]    rd_data_o,
  input  logic      [1:0]                   wr_en_i,
  input  log_reg_t  [1:0]                   wr_addr_i,
  input  phys_reg_t [1:0]                   wr_data_i,
  input  logic                              restore_i,
  input  phys_reg_t [LOG_REGS-1:0]          restore_data_i,
  output phys_reg_t [LOG_REGS-1:0]          table_q_o,
  output phys_reg_t [LOG_REGS-1:0]          table_d_o
);

  phys_reg_t [LOG_REGS-1:0] table_q;
  phys_reg_t [LOG_REGS-1:0] table_d;

  // Port 0 is applied before port 1 so the later slot overwrites on a tie.
  always_comb begin
    table_d = table_q;
    if (restore_i) begin
      table_d = restore_data_i;
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w] != '0)) begin
          table_d[wr_addr_i[w]] = wr_data_i[w];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      table_q <= '0;
    end else begin
      table_q <= table_d;
    end
  end

  always_comb begin
    for (int r = 0; r < RAT_READ_PORTS; r++) begin
      rd_data_o[r] = (rd_addr_i[r] == '0) ? '0 : table_q[rd_addr_i[r]];
    end
  end

  assign table_q_o = table_q;
  assign table_d_o = table_d;

endmodule

// File: rtl/rename_map.sv
// rename_map: two-wide register rename stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rename_map_if.slave carrying the decode group, freelist pop
//              interface, flush, renamed output group and retire updates.
// Looks up sources in the speculative RAT, pops fresh physical destinations,
// updates the speculative RAT and registers the renamed group (1-cycle latency).
// A committed RAT follows retire and is copied into the speculative RAT on flush.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is computed without looking at in_valid; out_valid, once set,
// holds with stable data until out_ready is seen (or a flush drops the group).
module rename_map
  import rename_map_pkg::*;
(
  input logic         clk,
  input logic         rst,
  rename_map_if.slave bus
);

  logic [DISPATCH_WIDTH-1:0]        alloc;
  logic [1:0]                       need;
  logic                             in_ready;
  logic                             fire;
  logic [DISPATCH_WIDTH-1:0]        spec_wr_en;

  log_reg_t  [RAT_READ_PORTS-1:0]   src_addr;
  phys_reg_t [RAT_READ_PORTS-1:0]   src_phys;
  phys_reg_t [LOG_REGS-1:0]         spec_tbl;
  phys_reg_t [LOG_REGS-1:0]         spec_next_unused;
  phys_reg_t [LOG_REGS-1:0]         commit_next;
  phys_reg_t [LOG_REGS-1:0]         commit_tbl_unused;
  phys_reg_t [RAT_READ_PORTS-1:0]   commit_rd_unused;

  rename_out_t [DISPATCH_WIDTH-1:0] grp;
  rename_out_t [DISPATCH_WIDTH-1:0] out_d;
  rename_out_t [DISPATCH_WIDTH-1:0] out_q;
  logic                             out_valid_d;
  logic                             out_valid_q;

  // A slot consumes a physical register only for a real write to a non-x0 rd.
  always_comb begin
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      alloc[i] = bus.in_inst_valid[i] && bus.in_rd_wen[i] && (bus.in_rd[i] != '0);
    end
  end

  assign need     = popcount2(alloc);
  assign in_ready = !bus.flush && (!out_valid_q || bus.out_ready) &&
                    (bus.fl_num_free >= free_cnt_t'(need));
  assign fire     = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  // Slot i always takes fl_pop_reg[i]; the freelist packs to match the mask.
  assign bus.fl_pop_en = fire ? alloc : '0;
  assign spec_wr_en    = fire ? alloc : '0;

  assign src_addr = {bus.in_rs2[1], bus.in_rs1[1], bus.in_rs2[0], bus.in_rs1[0]};

  rat_table u_spec_rat (
    .clk            (clk),
    .rst            (rst),
    .rd_addr_i      (src_addr),
    .rd_data_o      (src_phys),
    .wr_en_i        (spec_wr_en),
    .wr_addr_i      (bus.in_rd),
    .wr_data_i      (bus.fl_pop_reg),
    .restore_i      (bus.flush),
    .restore_data_i (commit_next),
    .table_q_o      (spec_tbl),
    .table_d_o      (spec_next_unused)
  );

  // The restore source is the committed table *after* this cycle's retire
  // writes, so a commit landing together with a flush is not lost.
  rat_table u_commit_rat (
    .clk            (clk),
    .rst            (rst),
    .rd_addr_i      ('0),
    .rd_data_o      (commit_rd_unused),
    .wr_en_i        (bus.commit_en),
    .wr_addr_i      (bus.commit_rd),
    .wr_data_i      (bus.commit_phys),
    .restore_i      (1'b0),
    .restore_data_i ('0),
    .table_q_o      (commit_tbl_unused),
    .table_d_o      (commit_next)
  );

  // Renamed group. Slot 1 sees slot 0's new mapping for any register slot 0
  // renames in the same group (sources and old destination alike).
  always_comb begin
    grp = '0;
    if (bus.in_inst_valid[0]) begin
      grp[0].inst_valid  = 1'b1;
      grp[0].rd_phys     = alloc[0] ? bus.fl_pop_reg[0] : '0;
      grp[0].old_rd_phys = spec_tbl[bus.in_rd[0]];
      grp[0].rs1_phys    = src_phys[0];
      grp[0].rs2_phys    = src_phys[1];
    end
    if (bus.in_inst_valid[1]) begin
      grp[1].inst_valid  = 1'b1;
      grp[1].rd_phys     = alloc[1] ? bus.fl_pop_reg[1] : '0;
      grp[1].old_rd_phys = (alloc[0] && (bus.in_rd[1] == bus.in_rd[0])) ?
                           bus.fl_pop_reg[0] : spec_tbl[bus.in_rd[1]];
      grp[1].rs1_phys    = (alloc[0] && (bus.in_rs1[1] == bus.in_rd[0])) ?
                           bus.fl_pop_reg[0] : src_phys[2];
      grp[1].rs2_phys    = (alloc[0] && (bus.in_rs2[1] == bus.in_rd[0])) ?
                           bus.fl_pop_reg[0] : src_phys[3];
    end
  end

  // Output stage: flush drops the group, fire loads a new one, otherwise the
  // group leaves when dispatch takes it and data holds while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d = 1'b1;
      out_d       = grp;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign bus.out_valid = out_valid_q;

  always_comb begin
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      bus.out_inst_valid[i]  = out_q[i].inst_valid;
      bus.out_rd_phys[i]     = out_q[i].rd_phys;
      bus.out_old_rd_phys[i] = out_q[i].old_rd_phys;
      bus.out_rs1_phys[i]    = out_q[i].rs1_phys;
      bus.out_rs2_phys[i]    = out_q[i].rs2_phys;
    end
  end

endmodule

// File: tb/tb_rename_map.sv
// Self-checking bench for rename_map: directed scenarios plus a random run,
// with a sequential reference rename model feeding an expected-output queue.
module tb_rename_map;
  import rename_map_pkg::*;

  localparam int W = 50;

  logic clk;
  logic rst;

  rename_map_if bus ();

  rename_map dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [5:0] m_spec   [32];
  logic [5:0] m_commit [32];
  logic       m_out_valid;

  function automatic logic [W-1:0] pack_out();
    return {bus.out_inst_valid,
            bus.out_rd_phys[1],     bus.out_rd_phys[0],
            bus.out_old_rd_phys[1], bus.out_old_rd_phys[0],
            bus.out_rs1_phys[1],    bus.out_rs1_phys[0],
            bus.out_rs2_phys[1],    bus.out_rs2_phys[0]};
  endfunction

  function automatic logic [W-1:0] exp_front();
    if (exp_q.size() == 0) return 'x;
    return exp_q[0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.in_valid      = 1'b0;
    bus.in_inst_valid = '0;
    bus.in_rd_wen     = '0;
    bus.in_rd         = '0;
    bus.in_rs1        = '0;
    bus.in_rs2        = '0;
    bus.fl_pop_reg    = '0;
    bus.fl_num_free   = 7'd63;
    bus.flush         = 1'b0;
    bus.out_ready     = 1'b1;
    bus.commit_en     = '0;
    bus.commit_rd     = '0;
    bus.commit_phys   = '0;
  endtask

  task automatic set_group(input logic [1:0] iv, input logic [1:0] wen,
                           input logic [4:0] rd0, input logic [4:0] a0, input logic [4:0] b0,
                           input logic [4:0] rd1, input logic [4:0] a1, input logic [4:0] b1,
                           input logic [5:0] p0, input logic [5:0] p1);
    bus.in_valid      = 1'b1;
    bus.in_inst_valid = iv;
    bus.in_rd_wen     = wen;
    bus.in_rd[0]  = rd0; bus.in_rs1[0] = a0; bus.in_rs2[0] = b0;
    bus.in_rd[1]  = rd1; bus.in_rs1[1] = a1; bus.in_rs2[1] = b1;
    bus.fl_pop_reg[0] = p0;
    bus.fl_pop_reg[1] = p1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Settles inputs, predicts ready/pop for this cycle and advances the model
  // to what the edge will do. Renaming is modelled slot by slot in program
  // order, which yields the intra-group forwarding naturally.
  task automatic pre_edge(output logic er, output logic [1:0] ep);
    logic [1:0] alloc;
    int         need;
    logic [5:0] v_rd[2], v_old[2], v_rs1[2], v_rs2[2];
    #1;
    for (int s = 0; s < 2; s++)
      alloc[s] = bus.in_inst_valid[s] && bus.in_rd_wen[s] && (bus.in_rd[s] != 0);
    need = int'(alloc[0]) + int'(alloc[1]);
    er = !bus.flush && (!m_out_valid || bus.out_ready) && (int'(bus.fl_num_free) >= need);
    ep = (bus.in_valid && er) ? alloc : 2'b00;
    if (m_out_valid && (bus.out_ready || bus.flush) && exp_q.size() > 0)
      void'(exp_q.pop_front());
    if (bus.in_valid && er) begin
      for (int s = 0; s < 2; s++) begin
        v_rd[s] = 0; v_old[s] = 0; v_rs1[s] = 0; v_rs2[s] = 0;
        if (bus.in_inst_valid[s]) begin
          v_rs1[s] = (bus.in_rs1[s] == 0) ? 6'd0 : m_spec[bus.in_rs1[s]];
          v_rs2[s] = (bus.in_rs2[s] == 0) ? 6'd0 : m_spec[bus.in_rs2[s]];
          v_old[s] = m_spec[bus.in_rd[s]];
          if (bus.in_rd_wen[s] && bus.in_rd[s] != 0) begin
            v_rd[s] = bus.fl_pop_reg[s];
            m_spec[bus.in_rd[s]] = bus.fl_pop_reg[s];
          end
        end
      end
      exp_q.push_back({bus.in_inst_valid, v_rd[1], v_rd[0], v_old[1], v_old[0],
                       v_rs1[1], v_rs1[0], v_rs2[1], v_rs2[0]});
    end
    for (int s = 0; s < 2; s++)
      if (bus.commit_en[s] && bus.commit_rd[s] != 0)
        m_commit[bus.commit_rd[s]] = bus.commit_phys[s];
    if (bus.flush)
      for (int r = 0; r < 32; r++) m_spec[r] = m_commit[r];
    if (bus.flush)                  m_out_valid = 1'b0;
    else if (bus.in_valid && er)    m_out_valid = 1'b1;
    else if (bus.out_ready)         m_out_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    for (int r = 0; r < 32; r++) begin m_spec[r] = 0; m_commit[r] = 0; end
    m_out_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (pack_out() !== '0) begin n_errors++; $display("FAIL reset_out_fields: got %h expected 0", pack_out()); end
    n_checks++;
    if (bus.fl_pop_en !== 2'b00) begin n_errors++; $display("FAIL reset_pop_en: got %b expected 00", bus.fl_pop_en); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic er; logic [1:0] ep;
    idle_inputs();
    set_group(2'b11, 2'b11, 5'd5, 5'd0, 5'd0, 5'd6, 5'd5, 5'd5, 6'd1, 6'd2);
    pre_edge(er, ep);
    n_checks++;
    if (bus.in_ready !== er) begin n_errors++; $display("FAIL basic_in_ready: got %b expected %b", bus.in_ready, er); end
    n_checks++;
    if (bus.fl_pop_en !== 2'b11) begin n_errors++; $display("FAIL basic_pop_en: got %b expected 11", bus.fl_pop_en); end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_out_valid: got %b expected 1", bus.out_valid); end
    n_checks++;
    if (pack_out() !== exp_front()) begin n_errors++; $display("FAIL basic_group: got %h expected %h", pack_out(), exp_front()); end
    n_checks++;
    if (bus.out_rs1_phys[1] !== 6'd1 || bus.out_rs2_phys[1] !== 6'd1)
      begin n_errors++; $display("FAIL basic_fwd: got %0d/%0d expected 1/1", bus.out_rs1_phys[1], bus.out_rs2_phys[1]); end
  endtask

  task automatic test_same_rd();
    logic er; logic [1:0] ep;
    idle_inputs();
    set_group(2'b11, 2'b11, 5'd7, 5'd1, 5'd2, 5'd7, 5'd3, 5'd4, 6'd3, 6'd4);
    pre_edge(er, ep);
    n_checks++;
    if (bus.fl_pop_en !== ep) begin n_errors++; $display("FAIL same_rd_pop_en: got %b expected %b", bus.fl_pop_en, ep); end
    tick();
    n_checks++;
    if (pack_out() !== exp_front()) begin n_errors++; $display("FAIL same_rd_group: got %h expected %h", pack_out(), exp_front()); end
    n_checks++;
    if (bus.out_old_rd_phys[1] !== 6'd3) begin n_errors++; $display("FAIL same_rd_old: got %0d expected 3", bus.out_old_rd_phys[1]); end
    // Slot 1 absent: its fields must come out zero.
    idle_inputs();
    set_group(2'b01, 2'b01, 5'd9, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 6'd5, 6'd33);
    pre_edge(er, ep);
    n_checks++;
    if (bus.fl_pop_en !== 2'b01) begin n_errors++; $display("FAIL same_rd_pop_en2: got %b expected 01", bus.fl_pop_en); end
    tick();
    n_checks++;
    if (pack_out() !== exp_front()) begin n_errors++; $display("FAIL same_rd_read: got %h expected %h", pack_out(), exp_front()); end
    n_checks++;
    if (bus.out_rs1_phys[0] !== 6'd4) begin n_errors++; $display("FAIL same_rd_rat: got %0d expected 4", bus.out_rs1_phys[0]); end
  endtask

  task automatic test_freelist_stall();
    logic er; logic [1:0] ep;
    idle_inputs();
    bus.fl_num_free = 7'd1;
    set_group(2'b11, 2'b11, 5'd10, 5'd9, 5'd7, 5'd11, 5'd10, 5'd0, 6'd6, 6'd7);
    pre_edge(er, ep);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready); end
    n_checks++;
    if (bus.fl_pop_en !== 2'b00) begin n_errors++; $display("FAIL stall_pop_en: got %b expected 00", bus.fl_pop_en); end
    tick();
    n_checks++;
    if (bus.out_valid !== m_out_valid) begin n_errors++; $display("FAIL stall_out_valid: got %b expected %b", bus.out_valid, m_out_valid); end
    bus.fl_num_free = 7'd2;
    pre_edge(er, ep);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL stall_release_ready: got %b expected 1", bus.in_ready); end
    n_checks++;
    if (bus.fl_pop_en !== 2'b11) begin n_errors++; $display("FAIL stall_release_pop: got %b expected 11", bus.fl_pop_en); end
    tick();
    n_checks++;
    if (pack_out() !== exp_front()) begin n_errors++; $display("FAIL stall_group: got %h expected %h", pack_out(), exp_front()); end
  endtask

  task automatic test_back_to_back();
    logic er; logic [1:0] ep;
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      bus.out_ready = 1'b0;
      set_group(2'b11, 2'b11, 5'd12, 5'd10, 5'd11, 5'd13, 5'd12, 5'd12, 6'd12, 6'd13);
      pre_edge(er, ep);
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready c%0d: got %b expected 0", c, bus.in_ready); end
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_out_valid c%0d: got %b expected 1", c, bus.out_valid); end
      n_checks++;
      if (pack_out() !== exp_front()) begin n_errors++; $display("FAIL bp_hold c%0d: got %h expected %h", c, pack_out(), exp_front()); end
    end
    bus.out_ready = 1'b1;
    pre_edge(er, ep);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
    tick();
    n_checks++;
    if (pack_out() !== exp_front()) begin n_errors++; $display("FAIL bp_release_group: got %h expected %h", pack_out(), exp_front()); end
  endtask

  task automatic test_flush_restore();
    logic er; logic [1:0] ep;
    idle_inputs();
    bus.commit_en = 2'b11;
    bus.commit_rd[0] = 5'd5; bus.commit_phys[0] = 6'd1;
    bus.commit_rd[1] = 5'd6; bus.commit_phys[1] = 6'd2;
    pre_edge(er, ep);
    tick();
    idle_inputs();
    set_group(2'b01, 2'b01, 5'd5, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 6'd9, 6'd0);
    pre_edge(er, ep);
    tick();
    n_checks++;
    if (bus.out_rd_phys[0] !== 6'd9) begin n_errors++; $display("FAIL flush_pre_rd: got %0d expected 9", bus.out_rd_phys[0]); end
    idle_inputs();
    bus.flush = 1'b1;
    set_group(2'b11, 2'b11, 5'd20, 5'd5, 5'd5, 5'd21, 5'd5, 5'd5, 6'd14, 6'd15);
    pre_edge(er, ep);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready); end
    n_checks++;
    if (bus.fl_pop_en !== 2'b00) begin n_errors++; $display("FAIL flush_pop_en: got %b expected 00", bus.fl_pop_en); end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid); end
    idle_inputs();
    set_group(2'b01, 2'b01, 5'd14, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0, 6'd18, 6'd0);
    pre_edge(er, ep);
    tick();
    n_checks++;
    if (bus.out_rs1_phys[0] !== 6'd1 || bus.out_rs2_phys[0] !== 6'd2)
      begin n_errors++; $display("FAIL flush_restore: got %0d/%0d expected 1/2", bus.out_rs1_phys[0], bus.out_rs2_phys[0]); end
    n_checks++;
    if (pack_out() !== exp_front()) begin n_errors++; $display("FAIL flush_group: got %h expected %h", pack_out(), exp_front()); end
  endtask

  task automatic test_flush_commit();
    logic er; logic [1:0] ep;
    idle_inputs();
    bus.flush = 1'b1;
    bus.commit_en = 2'b11;
    bus.commit_rd[0] = 5'd8;  bus.commit_phys[0] = 6'd10;
    bus.commit_rd[1] = 5'd0;  bus.commit_phys[1] = 6'd30;
    pre_edge(er, ep);
    tick();
    idle_inputs();
    bus.flush = 1'b1;
    bus.commit_en = 2'b11;
    bus.commit_rd[0] = 5'd12; bus.commit_phys[0] = 6'd20;
    bus.commit_rd[1] = 5'd12; bus.commit_phys[1] = 6'd21;
    pre_edge(er, ep);
    tick();
    idle_inputs();
    set_group(2'b11, 2'b00, 5'd1, 5'd8, 5'd12, 5'd2, 5'd0, 5'd5, 6'd0, 6'd0);
    pre_edge(er, ep);
    n_checks++;
    if (bus.fl_pop_en !== 2'b00) begin n_errors++; $display("FAIL fc_pop_en: got %b expected 00", bus.fl_pop_en); end
    tick();
    n_checks++;
    if (bus.out_rs1_phys[0] !== 6'd10) begin n_errors++; $display("FAIL fc_bypass: got %0d expected 10", bus.out_rs1_phys[0]); end
    n_checks++;
    if (bus.out_rs2_phys[0] !== 6'd21) begin n_errors++; $display("FAIL fc_slot1_wins: got %0d expected 21", bus.out_rs2_phys[0]); end
    n_checks++;
    if (pack_out() !== exp_front()) begin n_errors++; $display("FAIL fc_group: got %h expected %h", pack_out(), exp_front()); end
  endtask

  task automatic test_x0_dest();
    logic er; logic [1:0] ep;
    idle_inputs();
    bus.fl_num_free = 7'd1;
    set_group(2'b11, 2'b11, 5'd0, 5'd8, 5'd12, 5'd13, 5'd0, 5'd0, 6'd16, 6'd17);
    pre_edge(er, ep);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL x0_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++;
    if (bus.fl_pop_en !== 2'b10) begin n_errors++; $display("FAIL x0_pop_en: got %b expected 10", bus.fl_pop_en); end
    tick();
    n_checks++;
    if (bus.out_rd_phys[0] !== 6'd0 || bus.out_rd_phys[1] !== 6'd17)
      begin n_errors++; $display("FAIL x0_rd_phys: got %0d/%0d expected 0/17", bus.out_rd_phys[0], bus.out_rd_phys[1]); end
    n_checks++;
    if (pack_out() !== exp_front()) begin n_errors++; $display("FAIL x0_group: got %h expected %h", pack_out(), exp_front()); end
    idle_inputs();
    set_group(2'b11, 2'b00, 5'd0, 5'd13, 5'd0, 5'd0, 5'd8, 5'd0, 6'd0, 6'd0);
    pre_edge(er, ep);
    tick();
    n_checks++;
    if (bus.out_rs1_phys[0] !== 6'd17 || bus.out_old_rd_phys[0] !== 6'd0)
      begin n_errors++; $display("FAIL x0_rat: got %0d/%0d expected 17/0", bus.out_rs1_phys[0], bus.out_old_rd_phys[0]); end
  endtask

  task automatic test_random();
    logic er; logic [1:0] ep;
    for (int it = 0; it < 60; it++) begin
      idle_inputs();
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      bus.fl_num_free = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 2)) : 7'd63;
      set_group(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                6'($urandom_range(1, 63)), 6'($urandom_range(1, 63)));
      bus.in_valid  = ($urandom_range(0, 4) != 0);
      bus.commit_en = 2'($urandom_range(0, 3));
      bus.commit_rd[0] = 5'($urandom_range(0, 31)); bus.commit_phys[0] = 6'($urandom_range(1, 63));
      bus.commit_rd[1] = 5'($urandom_range(0, 31)); bus.commit_phys[1] = 6'($urandom_range(1, 63));
      bus.flush = ($urandom_range(0, 15) == 0);
      pre_edge(er, ep);
      n_checks++;
      if (bus.in_ready !== er) begin n_errors++; $display("FAIL rand_in_ready it%0d: got %b expected %b", it, bus.in_ready, er); end
      n_checks++;
      if (bus.fl_pop_en !== ep) begin n_errors++; $display("FAIL rand_pop_en it%0d: got %b expected %b", it, bus.fl_pop_en, ep); end
      tick();
      n_checks++;
      if (bus.out_valid !== m_out_valid) begin n_errors++; $display("FAIL rand_out_valid it%0d: got %b expected %b", it, bus.out_valid, m_out_valid); end
      if (m_out_valid) begin
        n_checks++;
        if (pack_out() !== exp_front()) begin n_errors++; $display("FAIL rand_group it%0d: got %h expected %h", it, pack_out(), exp_front()); end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_same_rd();
    test_freelist_stall();
    test_back_to_back();
    test_flush_restore();
    test_flush_commit();
    test_x0_dest();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
